// File: rtl/uart_rx_display_scroller_pkg.sv
// Shared types and helpers for the UART RX display scroller: display modes,
// capture FSM states and the ASCII-hex to nibble conversion.
package uart_rx_display_scroller_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT_UP   = 2'd0,
        MODE_SHIFT_DOWN = 2'd1,
        MODE_REPLACE    = 2'd2,
        MODE_RESERVED   = 2'd3
    } disp_mode_t;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_ACK      = 2'd1,
        CAP_WAIT_LOW = 2'd2
    } cap_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Non-hex characters map to zero so a garbled byte still shows something sane.
    function automatic logic [3:0] ascii2nib(input logic [7:0] c);
        logic [3:0] n;
        n = 4'h0;
        if (c >= 8'h30 && c <= 8'h39)
            n = 4'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h46)
            n = 4'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h66)
            n = 4'(c - 8'h57);
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_display_scroller_if.sv
// Byte handshake between the UART core (master) and the display scroller (slave).
interface uart_rx_display_scroller_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_flag;
    logic              rx_parity_error;
    logic              rx_flag_clr;

    modport master (
        output rx_data,
        output rx_flag,
        output rx_parity_error,
        input  rx_flag_clr
    );

    modport slave (
        input  rx_data,
        input  rx_flag,
        input  rx_parity_error,
        output rx_flag_clr
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// Hex nibble to seven-segment pattern, seg = {g,f,e,d,c,b,a}, active-high.
module seven_segment_decoder (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/uart_nibble_fifo.sv
// Small synchronous FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_display_scroller.sv
// Acknowledges UART bytes, buffers their hex nibbles and scrolls them onto a
// row of seven-segment digits at a programmable tick rate.
//
//   state        | meaning
//   CAP_IDLE     | waiting for rx_flag; byte is evaluated on the cycle it is seen
//   CAP_ACK      | rx_flag_clr pulsed for this one cycle
//   CAP_WAIT_LOW | waiting for the UART core to drop rx_flag
module uart_rx_display_scroller
    import uart_rx_display_scroller_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_DISP     = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int SCROLL_DIV = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_rx_display_scroller_if.slave   rx_if,
    input  logic [1:0]                  mode,
    input  logic                        freeze,
    input  logic                        clear,
    output logic [N_DISP-1:0][6:0]      displays,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [7:0]                  err_cnt
);
    localparam int TICK_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    cap_state_t              cap_state_q;
    cap_state_t              cap_state_d;
    logic                    capture;
    logic                    push_req;
    logic                    pop_req;
    logic                    tick;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [3:0]              pop_nib;
    logic [DATA_W-1:0]       rx_byte;
    logic [N_DISP-1:0][3:0]  digit_q;
    logic [N_DISP-1:0][3:0]  digit_d;

    assign rx_byte = rx_if.rx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cap_state_q <= CAP_IDLE;
        else
            cap_state_q <= cap_state_d;
    end

    always_comb begin
        cap_state_d = cap_state_q;
        case (cap_state_q)
            CAP_IDLE:     if (rx_if.rx_flag) cap_state_d = CAP_ACK;
            CAP_ACK:      cap_state_d = CAP_WAIT_LOW;
            CAP_WAIT_LOW: if (!rx_if.rx_flag) cap_state_d = CAP_IDLE;
            default:      cap_state_d = CAP_IDLE;
        endcase
    end

    always_comb begin
        capture           = (cap_state_q == CAP_IDLE) && rx_if.rx_flag;
        rx_if.rx_flag_clr = (cap_state_q == CAP_ACK);
    end

    assign push_req = capture && !rx_if.rx_parity_error;
    assign pop_req  = tick && !freeze && !clear && !fifo_empty;

    // Free-running even under freeze so the scroll phase stays steady.
    assign tick = (tick_cnt == TICK_W'(SCROLL_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    uart_nibble_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req),
        .pop     (pop_req),
        .flush   (clear),
        .wr_data (ascii2nib(rx_byte[7:0])),
        .rd_data (pop_nib),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A drop is only an overflow when no same-cycle pop made room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (push_req && fifo_full && !pop_req)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (capture && rx_if.rx_parity_error && err_cnt != ERR_CNT_MAX)
            err_cnt <= err_cnt + 1'b1;
    end

    always_comb begin
        digit_d = digit_q;
        if (pop_req) begin
            case (disp_mode_t'(mode))
                MODE_SHIFT_DOWN: begin
                    for (int i = 0; i < N_DISP - 1; i++)
                        digit_d[i] = digit_q[i+1];
                    digit_d[N_DISP-1] = pop_nib;
                end
                MODE_REPLACE: begin
                    digit_d[0] = pop_nib;
                end
                default: begin
                    for (int i = N_DISP - 1; i >= 1; i--)
                        digit_d[i] = digit_q[i-1];
                    digit_d[0] = pop_nib;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digit_q <= '0;
        else if (clear)
            digit_q <= '0;
        else
            digit_q <= digit_d;
    end

    for (genvar g = 0; g < N_DISP; g++) begin : g_dec
        seven_segment_decoder u_dec (
            .nib (digit_q[g]),
            .seg (displays[g])
        );
    end
endmodule

// File: tb/tb_uart_rx_display_scroller.sv
// Bench for the display scroller: two instances (scroll every cycle and every
// fourth cycle) share one stimulus stream and are checked against a queue model.
module tb_uart_rx_display_scroller;
    localparam int ND    = 6;
    localparam int DEPTH = 8;
    localparam int DIV_M [2] = '{1, 4};

    logic clk = 1'b0;
    logic rst;
    logic [1:0] mode;
    logic freeze, clear, rx_flag, rx_pe;
    logic [7:0] rx_data;

    logic [ND-1:0][6:0] disp1, disp4;
    logic [3:0] cnt1, cnt4;
    logic ovf1, ovf4;
    logic [7:0] err1, err4;

    int n_pass = 0;
    int n_checks = 0;
    bit cmp_en = 0;
    int clr_pulses = 0;

    uart_rx_display_scroller_if #(.DATA_W(8)) if1 ();
    uart_rx_display_scroller_if #(.DATA_W(8)) if4 ();

    assign if1.rx_data = rx_data;
    assign if1.rx_flag = rx_flag;
    assign if1.rx_parity_error = rx_pe;
    assign if4.rx_data = rx_data;
    assign if4.rx_flag = rx_flag;
    assign if4.rx_parity_error = rx_pe;

    uart_rx_display_scroller #(.DATA_W(8), .N_DISP(ND), .FIFO_DEPTH(DEPTH), .SCROLL_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx_if(if1), .mode(mode), .freeze(freeze), .clear(clear),
        .displays(disp1), .fifo_count(cnt1), .overflow(ovf1), .err_cnt(err1));

    uart_rx_display_scroller #(.DATA_W(8), .N_DISP(ND), .FIFO_DEPTH(DEPTH), .SCROLL_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .rx_if(if4), .mode(mode), .freeze(freeze), .clear(clear),
        .displays(disp4), .fifo_count(cnt4), .overflow(ovf4), .err_cnt(err4));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int a2n(input int c);
        if (c >= 48 && c <= 57)  return c - 48;
        if (c >= 65 && c <= 70)  return c - 55;
        if (c >= 97 && c <= 102) return c - 87;
        return 0;
    endfunction

    // Behavioural model: nibble queue, digit row, sticky flags, handshake phase.
    int md [2][ND];
    int mq [2][DEPTH];
    int mcnt [2];
    int medge [2];
    int merr [2];
    bit movf [2];
    int mphase;
    bit m_cap, m_tick;
    int m_nib;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0; medge[k] = 0; merr[k] = 0; movf[k] = 0;
                for (int i = 0; i < ND; i++) md[k][i] = 0;
            end
            mphase = 0;
        end else begin
            m_cap = (mphase == 0) && rx_flag;
            for (int k = 0; k < 2; k++) begin
                m_tick = (medge[k] % DIV_M[k]) == DIV_M[k] - 1;
                medge[k]++;
                if (clear) begin
                    mcnt[k] = 0;
                    movf[k] = 0;
                    for (int i = 0; i < ND; i++) md[k][i] = 0;
                end else begin
                    if (m_tick && !freeze && mcnt[k] > 0) begin
                        m_nib = mq[k][0];
                        for (int j = 0; j < DEPTH - 1; j++) mq[k][j] = mq[k][j+1];
                        mcnt[k]--;
                        if (mode == 2'd1) begin
                            for (int i = 0; i < ND - 1; i++) md[k][i] = md[k][i+1];
                            md[k][ND-1] = m_nib;
                        end else if (mode == 2'd2) begin
                            md[k][0] = m_nib;
                        end else begin
                            for (int i = ND - 1; i >= 1; i--) md[k][i] = md[k][i-1];
                            md[k][0] = m_nib;
                        end
                    end
                    if (m_cap && !rx_pe) begin
                        if (mcnt[k] < DEPTH) begin
                            mq[k][mcnt[k]] = a2n(int'(rx_data));
                            mcnt[k]++;
                        end else begin
                            movf[k] = 1;
                        end
                    end
                end
                if (m_cap && rx_pe && merr[k] < 255) merr[k]++;
            end
            if (m_cap) mphase = 1;
            else if (mphase == 1) mphase = 2;
            else if (mphase == 2 && !rx_flag) mphase = 0;
        end
    end

    function automatic logic [ND*7-1:0] exp_disp(input int k);
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) r[i*7 +: 7] = seg(md[k][i]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && if1.rx_flag_clr) clr_pulses++;
        if (!rst && cmp_en) begin
            chk("d1_disp", disp1, exp_disp(0));
            chk("d1_cnt", cnt1, mcnt[0]);
            chk("d1_ovf", ovf1, movf[0]);
            chk("d1_err", err1, merr[0]);
            chk("d1_clr", if1.rx_flag_clr, mphase == 1);
            chk("d4_disp", disp4, exp_disp(1));
            chk("d4_cnt", cnt4, mcnt[1]);
            chk("d4_ovf", ovf4, movf[1]);
            chk("d4_err", err4, merr[1]);
            chk("d4_clr", if4.rx_flag_clr, mphase == 1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic pe);
        bit got;
        rx_data = b;
        rx_pe = pe;
        rx_flag = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if1.rx_flag_clr) got = 1;
        end
        chk("ack_seen", got, 1);
        rx_flag = 1'b0;
        rx_pe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    int p0;
    int tchg[$];
    logic [ND-1:0][6:0] prev4;
    string hx = "0123456789ABCDEFabcdef";
    int src, hold;
    bit got6;

    initial begin
        rst = 1'b1; mode = 2'd0; freeze = 0; clear = 0;
        rx_flag = 0; rx_pe = 0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cnt", cnt1, 0);
        chk("rst_err", err1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_clr", if1.rx_flag_clr, 0);
        chk("rst_disp0", disp1[0], 7'h3F);
        chk("rst_disp5_d4", disp4[5], 7'h3F);
        rst = 1'b0;
        cmp_en = 1;
        @(negedge clk);

        // '3','A','f' scroll up
        p0 = clr_pulses;
        send_byte(8'h33, 0);
        send_byte(8'h41, 0);
        send_byte(8'h66, 0);
        repeat (10) @(negedge clk);
        chk("t1_pulses", clr_pulses - p0, 3);
        chk("t1_d0", disp1[0], 7'h71);
        chk("t1_d1", disp1[1], 7'h77);
        chk("t1_d2", disp1[2], 7'h4F);
        chk("t1_cnt", cnt1, 0);

        // frozen FIFO overflows, then drains in order
        pulse_clear();
        freeze = 1;
        for (int i = 0; i < 10; i++) send_byte(8'(48 + i), 0);
        chk("t2_cnt", cnt1, 8);
        chk("t2_ovf", ovf1, 1);
        chk("t2_frozen_d0", disp1[0], 7'h3F);
        freeze = 0;
        repeat (40) @(negedge clk);
        chk("t2_d0", disp1[0], 7'h07);
        chk("t2_d5", disp1[5], 7'h5B);
        chk("t2_d5_d4", disp4[5], 7'h5B);
        chk("t2_empty", cnt1, 0);

        // parity errors are counted and dropped
        pulse_clear();
        chk("t3_err0", err1, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h35, 1);
        chk("t3_err3", err1, 3);
        send_byte(8'h37, 0);
        repeat (6) @(negedge clk);
        chk("t3_d0", disp1[0], 7'h07);
        chk("t3_d1", disp1[1], 7'h3F);
        for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)), 1);
        chk("t3_sat", err1, 255);
        chk("t3_sat_d4", err4, 255);

        // slow scroll, shift down
        pulse_clear();
        mode = 2'd1;
        prev4 = disp4;
        fork
            begin
                send_byte(8'h31, 0);
                send_byte(8'h32, 0);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (disp4 != prev4) begin
                        tchg.push_back(c);
                        prev4 = disp4;
                    end
                end
            end
        join
        chk("t4_changes", tchg.size(), 2);
        chk("t4_spacing", (tchg.size() >= 2) ? tchg[1] - tchg[0] : -1, 4);
        chk("t4_top", disp4[5], 7'h5B);
        chk("t4_next", disp4[4], 7'h06);

        // push into full FIFO on a pop cycle, then clear over a pending pop
        pulse_clear();
        mode = 2'd0;
        freeze = 1;
        for (int i = 1; i <= 8; i++) send_byte(8'(48 + i), 0);
        chk("t5_full", cnt1, 8);
        rx_data = 8'h39; rx_pe = 0; rx_flag = 1; freeze = 0;
        @(negedge clk);
        freeze = 1;
        chk("t5_cnt_kept", cnt1, 8);
        chk("t5_no_ovf", ovf1, 0);
        chk("t5_acked", if1.rx_flag_clr, 1);
        rx_flag = 0;
        repeat (2) @(negedge clk);
        freeze = 0;
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("t5_clr_cnt", cnt1, 0);
        chk("t5_clr_disp", disp1[0], 7'h3F);
        chk("t5_err_kept", err1, 255);

        // async reset in the middle of an acknowledge
        pulse_clear();
        rx_data = 8'h35; rx_pe = 0; rx_flag = 1;
        @(posedge clk);
        #3;
        chk("t6_in_ack", if1.rx_flag_clr, 1);
        rst = 1'b1;
        #1;
        chk("t6_clr", if1.rx_flag_clr, 0);
        chk("t6_cnt", cnt1, 0);
        chk("t6_err", err1, 0);
        chk("t6_ovf", ovf1, 0);
        chk("t6_disp", disp1[0], 7'h3F);
        chk("t6_err_d4", err4, 0);
        rst = 1'b0;
        p0 = clr_pulses;
        got6 = 0;
        for (int i = 0; i < 20 && !got6; i++) begin
            @(negedge clk);
            if (if1.rx_flag_clr) got6 = 1;
        end
        chk("t6_ack_seen", got6, 1);
        rx_flag = 0;
        repeat (10) @(negedge clk);
        chk("t6_pulses", clr_pulses - p0, 1);
        chk("t6_d0", disp1[0], 7'h6D);

        // randomized traffic
        src = 0; hold = 0;
        for (int c = 0; c < 3000; c++) begin
            mode = 2'($urandom_range(0, 3));
            freeze = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 39) == 0);
            if (src == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    rx_data = ($urandom_range(0, 1) == 1) ? hx[$urandom_range(0, 21)]
                                                          : 8'($urandom_range(0, 255));
                    rx_pe = ($urandom_range(0, 7) == 0);
                    rx_flag = 1;
                    src = 1;
                end
            end else if (src == 1) begin
                if (if1.rx_flag_clr) begin
                    hold = $urandom_range(0, 2);
                    if (hold == 0) begin
                        rx_flag = 0;
                        src = 0;
                    end else begin
                        src = 2;
                    end
                end
            end else begin
                hold--;
                if (hold <= 0) begin
                    rx_flag = 0;
                    src = 0;
                end
            end
            @(negedge clk);
        end
        rx_flag = 0; freeze = 0; clear = 0;
        repeat (50) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
